rv32i_single_cycle_core: RTL and testbench

- Single-cycle RV32I-subset processor; the top-level compute block of the design.
- Contains the program counter, a 32x32 register file (instance `reg_file`, array `regfile`), instruction ROM, data RAM, decoder and ALU.
- Retires one instruction per clock until it halts.
- Self-contained: only clock and reset are required inputs. Debug outputs are provided for verification.

---
 rtl/rv32i_single_cycle_core.sv | 145 ++++++++++++++
 tb/tb_rv32i_single_cycle_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_single_cycle_core.sv
// rv32i_single_cycle_core: single-cycle RV32I subset core with ROM, RAM and register file.
// Define CPU_MUL_EN to add the MUL instruction.
module rv32i_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3
);
  logic [31:0][31:0] regfile;
  always_ff @(posedge clk)
    if (rst) regfile <= '0;
    else if (we && waddr != 5'd0) regfile[waddr] <= wdata;
  assign rd1 = (ra1 == 5'd0) ? '0 : regfile[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regfile[ra2];
  assign rd3 = (ra3 == 5'd0) ? '0 : regfile[ra3];
endmodule

module rv32i_single_cycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter string       IMEM_INIT  = "program.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  dbg_reg_sel,
  output logic [31:0] dbg_reg_data,
  output logic [31:0] dbg_pc,
  output logic        halted
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] pc, instr, rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_res, sra_res, daddr, load_data, mul_res, wdata, next_pc;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_lw, is_sw, is_opimm, is_op, is_mul, is_ebreak;
  logic alt, lt, ltu, taken, d_ok, we, unused_bits;

  assign instr  = ({2'b0, pc[31:2]} < 32'(IMEM_WORDS)) ? imem[pc[IW+1:2]] : 32'h0000_0013;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign is_lui    = opcode == 7'b0110111;
  assign is_auipc  = opcode == 7'b0010111;
  assign is_jal    = opcode == 7'b1101111;
  assign is_jalr   = opcode == 7'b1100111 && f3 == 3'd0;
  assign is_branch = opcode == 7'b1100011 && f3[2:1] != 2'b01;
  assign is_lw     = opcode == 7'b0000011 && f3 == 3'b010;
  assign is_sw     = opcode == 7'b0100011 && f3 == 3'b010;
  assign is_opimm  = opcode == 7'b0010011 &&
                     (f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
  assign is_op     = opcode == 7'b0110011 &&
                     (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
  assign is_ebreak = instr == 32'h0010_0073;
`ifdef CPU_MUL_EN
  assign is_mul  = opcode == 7'b0110011 && f7 == 7'h01 && f3 == 3'd0;
  assign mul_res = rs1v * rs2v;
`else
  assign is_mul  = 1'b0;
  assign mul_res = '0;
`endif

  rv32i_reg_file reg_file (
    .clk(clk), .rst(rst), .we(we), .waddr(rd), .wdata(wdata),
    .ra1(rs1), .ra2(rs2), .ra3(dbg_reg_sel),
    .rd1(rs1v), .rd2(rs2v), .rd3(dbg_reg_data)
  );

  // instr[30] selects SUB/SRA only where the encoding defines it, never on ADDI immediates
  assign alu_b   = is_op ? rs2v : imm_i;
  assign shamt   = alu_b[4:0];
  assign alt     = instr[30] && (is_op || f3 == 3'd5);
  assign sra_res = $signed(rs1v) >>> shamt;

  always_comb begin
    alu_res = '0;
    case (f3)
      3'd0: alu_res = alt ? rs1v - alu_b : rs1v + alu_b;
      3'd1: alu_res = rs1v << shamt;
      3'd2: alu_res = {31'b0, $signed(rs1v) < $signed(alu_b)};
      3'd3: alu_res = {31'b0, rs1v < alu_b};
      3'd4: alu_res = rs1v ^ alu_b;
      3'd5: alu_res = alt ? sra_res : rs1v >> shamt;
      3'd6: alu_res = rs1v | alu_b;
      3'd7: alu_res = rs1v & alu_b;
      default: alu_res = '0;
    endcase
  end

  assign lt    = $signed(rs1v) < $signed(rs2v);
  assign ltu   = rs1v < rs2v;
  assign taken = f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : ((rs1v == rs2v) ^ f3[0]);

  assign daddr       = rs1v + (is_sw ? imm_s : imm_i);
  assign d_ok        = {2'b0, daddr[31:2]} < 32'(DMEM_WORDS);
  assign load_data   = d_ok ? dmem[daddr[DW+1:2]] : '0;
  assign unused_bits = ^daddr[1:0];

  assign we    = !halted && (is_lui || is_auipc || is_jal || is_jalr || is_lw || is_opimm || is_op || is_mul);
  assign wdata = is_lui ? imm_u :
                 is_auipc ? pc + imm_u :
                 (is_jal || is_jalr) ? pc + 32'd4 :
                 is_lw ? load_data :
                 is_mul ? mul_res : alu_res;

  assign next_pc = is_jal ? pc + imm_j :
                   is_jalr ? (rs1v + imm_i) & ~32'd1 :
                   (is_branch && taken) ? pc + imm_b :
                   is_ebreak ? pc : pc + 32'd4;

  always_ff @(posedge clk)
    if (rst) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (!halted) begin
      pc     <= next_pc;
      halted <= is_ebreak;
    end

  always_ff @(posedge clk)
    if (!rst && !halted && is_sw && d_ok) dmem[daddr[DW+1:2]] <= rs2v;

  assign dbg_pc = pc;
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb_rv32i_single_cycle_core: directed program table plus random ALU programs against an ISA model.
module tb_rv32i_single_cycle_core;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef CPU_MUL_EN
  localparam logic [31:0] MUL_EXP = 32'd81;
`else
  localparam logic [31:0] MUL_EXP = 32'd0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  dbg_reg_sel = 5'd0;
  logic [31:0] dbg_reg_data, dbg_pc;
  logic        halted;
  int total = 0, bad = 0;

  rv32i_single_cycle_core #(.IMEM_INIT("")) dut (
    .clk(clk), .rst(rst), .dbg_reg_sel(dbg_reg_sel),
    .dbg_reg_data(dbg_reg_data), .dbg_pc(dbg_pc), .halted(halted)
  );

  always #50 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    int          prog;
    int          cyc;
    int          sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [31:0] progs [9][12];
  logic [31:0] img [64];
  logic [31:0] m [32];

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    return {20'(imm20), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction

  // Architectural model for straight-line LUI / OP-IMM / OP code
  task automatic iss(input logic [31:0] w);
    logic [31:0] a, b, r, sra;
    int sh;
    a = m[w[19:15]];
    b = (w[6:0] == 7'h33) ? m[w[24:20]] : {{20{w[31]}}, w[31:20]};
    sh = int'(b[4:0]);
    sra = $signed(a) >>> sh;
    case (w[14:12])
      3'd0: r = (w[6:0] == 7'h33 && w[30]) ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = w[30] ? sra : a >> sh;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (w[6:0] == 7'h37) r = {w[31:12], 12'b0};
    if (w[11:7] != 5'd0) m[w[11:7]] = r;
  endtask

  task automatic load_img();
    for (int i = 0; i < 256; i++) dut.imem[i] = (i < 64) ? img[i] : NOP;
  endtask
  task automatic start();
    rst = 1'b1;
    load_img();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic peek(int sel, output logic [31:0] v);
    if (sel == 32) v = dbg_pc;
    else if (sel == 33) v = {31'b0, halted};
    else begin
      dbg_reg_sel = 5'(sel);
      #1 v = dbg_reg_data;
    end
  endtask
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int p = 0; p < 9; p++) for (int i = 0; i < 12; i++) progs[p][i] = NOP;
    progs[0][0:4] = '{addi(1,0,5), addi(2,0,7), enc_r(0,2,1,0,3), enc_r('h20,2,1,0,4), EBREAK};
    progs[1][0:3] = '{addi(1,0,3), addi(1,1,-1), enc_b(-4,0,1,1), EBREAK};
    progs[2][0:4] = '{enc_u('h12345,5,'h37), enc_s(8,5,0), enc_i(8,0,2,6,3), addi(0,0,1), EBREAK};
    progs[3][0:5] = '{enc_j(8,1), addi(2,0,1), addi(3,0,-16), enc_i('h402,3,5,4,'h13),
                      enc_i(28,3,5,5,'h13), EBREAK};
    progs[4][0:5] = '{addi(1,0,9), 32'hFFFF_FFFF, enc_r(1,1,1,0,2), 32'h0000_0073,
                      enc_i(0,0,0,3,3), EBREAK};
    progs[5][0:3] = '{addi(1,0,13), enc_i(0,1,0,2,'h67), addi(3,0,1), enc_b(0,0,0,0)};
    progs[6][0:7] = '{addi(1,0,77), enc_s(0,1,0), enc_u(1,2,'h37), addi(3,0,55), enc_s(0,3,2),
                      enc_i(0,0,2,4,3), enc_i(0,2,2,5,3), EBREAK};
    progs[7][0:1] = '{enc_u(1,1,'h37), enc_i(0,1,0,0,'h67)};
    progs[8][0:10] = '{addi(1,0,-1), addi(2,0,1), enc_b(8,2,1,4), addi(10,0,1), enc_b(8,2,1,6),
                       addi(11,0,1), enc_b(8,1,2,5), addi(12,0,1), enc_b(8,1,2,7), addi(13,0,1), EBREAK};

    vecs.push_back('{"alu_nohalt", 0, 4, 33, 32'd0});
    vecs.push_back('{"alu_pc4", 0, 4, 32, 32'h10});
    vecs.push_back('{"alu_x3", 0, 5, 3, 32'd12});
    vecs.push_back('{"alu_x4", 0, 5, 4, 32'hFFFF_FFFE});
    vecs.push_back('{"alu_halt", 0, 5, 33, 32'd1});
    vecs.push_back('{"alu_pc", 0, 5, 32, 32'h10});
    vecs.push_back('{"halt_hold", 0, 12, 32, 32'h10});
    vecs.push_back('{"loop_mid", 1, 3, 1, 32'd2});
    vecs.push_back('{"loop_7", 1, 7, 33, 32'd0});
    vecs.push_back('{"loop_halt", 1, 8, 33, 32'd1});
    vecs.push_back('{"loop_pc", 1, 8, 32, 32'd12});
    vecs.push_back('{"loop_x1", 1, 8, 1, 32'd0});
    vecs.push_back('{"mem_x6", 2, 5, 6, 32'h1234_5000});
    vecs.push_back('{"mem_x5", 2, 5, 5, 32'h1234_5000});
    vecs.push_back('{"mem_x0", 2, 5, 0, 32'd0});
    vecs.push_back('{"mem_pc", 2, 5, 32, 32'h10});
    vecs.push_back('{"jal_pc", 3, 1, 32, 32'd8});
    vecs.push_back('{"jal_x1", 3, 5, 1, 32'd4});
    vecs.push_back('{"jal_x2", 3, 5, 2, 32'd0});
    vecs.push_back('{"srai_x4", 3, 5, 4, 32'hFFFF_FFFC});
    vecs.push_back('{"srli_x5", 3, 5, 5, 32'hF});
    vecs.push_back('{"jal_end_pc", 3, 5, 32, 32'd20});
    vecs.push_back('{"illegal_pc", 4, 2, 32, 32'd8});
    vecs.push_back('{"illegal_x1", 4, 2, 1, 32'd9});
    vecs.push_back('{"illegal_x31", 4, 2, 31, 32'd0});
    vecs.push_back('{"mul_x2", 4, 6, 2, MUL_EXP});
    vecs.push_back('{"lb_x3", 4, 6, 3, 32'd0});
    vecs.push_back('{"illegal_end_pc", 4, 6, 32, 32'd20});
    vecs.push_back('{"illegal_halt", 4, 6, 33, 32'd1});
    vecs.push_back('{"selfloop_pc", 5, 10, 32, 32'd12});
    vecs.push_back('{"jalr_x2", 5, 10, 2, 32'd8});
    vecs.push_back('{"jalr_skip_x3", 5, 10, 3, 32'd0});
    vecs.push_back('{"selfloop_nohalt", 5, 10, 33, 32'd0});
    vecs.push_back('{"sw_in_range", 6, 8, 4, 32'd77});
    vecs.push_back('{"lw_oob", 6, 8, 5, 32'd0});
    vecs.push_back('{"fetch_oob_pc", 7, 5, 32, 32'h100C});
    vecs.push_back('{"fetch_oob_x1", 7, 5, 1, 32'h1000});
    vecs.push_back('{"blt_taken", 8, 9, 10, 32'd0});
    vecs.push_back('{"bltu_not", 8, 9, 11, 32'd1});
    vecs.push_back('{"bge_taken", 8, 9, 12, 32'd0});
    vecs.push_back('{"bgeu_not", 8, 9, 13, 32'd1});
    vecs.push_back('{"branch_pc", 8, 9, 32, 32'd40});

    foreach (vecs[k]) begin
      for (int i = 0; i < 64; i++) img[i] = (i < 12) ? progs[vecs[k].prog][i] : NOP;
      start();
      run(vecs[k].cyc);
      peek(vecs[k].sel, v);
      check(vecs[k].name, v, vecs[k].exp);
    end

    // Reset after a run clears registers and state; first instruction retires on the first edge
    for (int i = 0; i < 64; i++) img[i] = (i < 12) ? progs[2][i] : NOP;
    start();
    run(5);
    rst = 1'b1;
    run(2);
    check("rst_pc", dbg_pc, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    for (int r = 0; r < 32; r++) begin
      peek(r, v);
      check($sformatf("rst_x%0d", r), v, 32'd0);
    end
    rst = 1'b0;
    run(1);
    check("first_retire_pc", dbg_pc, 32'd4);
    peek(5, v);
    check("first_retire_x5", v, 32'h1234_5000);

    // One-cycle reset in the middle of the loop restarts it
    for (int i = 0; i < 64; i++) img[i] = (i < 12) ? progs[1][i] : NOP;
    start();
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("midrst_pc", dbg_pc, 32'd0);
    peek(1, v);
    check("midrst_x1", v, 32'd0);
    run(1);
    peek(1, v);
    check("midrst_restart_x1", v, 32'd3);
    check("midrst_restart_pc", dbg_pc, 32'd4);

    // Random straight-line ALU programs against the model
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < 32; r++) m[r] = 32'd0;
      for (int i = 0; i < 64; i++) img[i] = NOP;
      for (int i = 0; i < 40; i++) begin
        int kind = $urandom_range(0, 2);
        int rd = $urandom_range(0, 31);
        int rs1 = $urandom_range(0, 31);
        int rs2 = $urandom_range(0, 31);
        int f3 = $urandom_range(0, 7);
        int sh = $urandom_range(0, 31);
        int hi = $urandom_range(0, 1) ? 'h400 : 0;
        if (kind == 0) img[i] = enc_u($urandom_range(0, 'hFFFFF), rd, 'h37);
        else if (kind == 1)
          img[i] = enc_i(f3 == 1 ? sh : f3 == 5 ? (hi | sh) : $urandom_range(0, 4095), rs1, f3, rd, 'h13);
        else img[i] = enc_r(((f3 == 0 || f3 == 5) && hi != 0) ? 'h20 : 0, rs2, rs1, f3, rd);
        iss(img[i]);
      end
      img[40] = EBREAK;
      start();
      run(41);
      check($sformatf("rand%0d_halt", it), {31'b0, halted}, 32'd1);
      for (int r = 0; r < 32; r++) begin
        peek(r, v);
        check($sformatf("rand%0d_x%0d", it, r), v, m[r]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
